oneapi_axi_video_line_regulator: RTL and testbench



---
 rtl/oneapi_video_pkg.sv | 22 ++
 rtl/oneapi_axis_skid_buffer.sv | 65 ++++++
 rtl/oneapi_axi_video_line_regulator.sv | 235 +++++++++++++++++++++++
 tb/tb_oneapi_axi_video_line_regulator.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oneapi_video_pkg.sv
// Shared types and constants for the oneAPI video line regulator.
//   state_t        : regulator FSM states
//   TUSER_SOF_BIT  : tuser bit carrying start-of-frame
//   STAT_CNT_BITS  : width of the optional saturating statistics counters
//   sat_inc()      : saturating increment used by the statistics counters
package oneapi_video_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        PAD  = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam int TUSER_SOF_BIT = 0;
    localparam int STAT_CNT_BITS = 16;

    function automatic logic [STAT_CNT_BITS-1:0] sat_inc(input logic [STAT_CNT_BITS-1:0] v);
        return (&v) ? v : v + STAT_CNT_BITS'(1);
    endfunction

endpackage

// File: rtl/oneapi_axis_skid_buffer.sv
// Two-entry AXI4-Stream skid buffer. The output is always driven from the
// head register and in_ready depends only on the occupancy register, so no
// combinational path runs from out_ready to in_ready.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
module oneapi_axis_skid_buffer #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data
);

    logic [1:0]           count_q;
    logic [DATA_BITS-1:0] head_q;
    logic [DATA_BITS-1:0] skid_q;
    logic                 push;
    logic                 pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= in_data;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= in_data;
                    end else if (push) begin
                        skid_q  <= in_data;
                        count_q <= 2'd2;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_q  <= skid_q;
                        count_q <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/oneapi_axi_video_line_regulator.sv
// Enforces programmed frame geometry on an AXI4-S video stream (tuser[0]=SOF,
// tlast=EOL). Short lines are padded with zero beats, long lines truncated,
// and an early SOF closes the current frame with padding before it is taken.
// SOF/EOL on the output are regenerated from the col/row counters.
//
//   csi_clk, rsi_reset_n        : clock, synchronous active-low reset
//   cfg_width_beats, cfg_height : geometry, latched when an SOF is accepted
//   axs_*                       : AXI4-S sink (from the Avalon-to-AXI gasket)
//   axm_*                       : AXI4-S source, registered via skid buffer
//   stat_pad/trunc/drop         : one-cycle event pulses
//   Optional (ONEAPI_LINE_REGULATOR_STATS_EN): stat_clear input and 16-bit
//   saturating stat_pad_count, stat_trunc_count, stat_drop_count outputs.
//
// state | meaning
// IDLE  | waiting for SOF; non-SOF beats are discarded
// PASS  | forwarding input beats, counting col/row
// PAD   | emitting zero beats to end of line (or end of frame after early SOF)
// DROP  | discarding surplus beats of a truncated line up to its tlast
module oneapi_axi_video_line_regulator
    import oneapi_video_pkg::*;
#(
    parameter int BITS_AXI    = 24,
    parameter int TUSER_BITS  = 3,
    parameter int WIDTH_BITS  = 16,
    parameter int HEIGHT_BITS = 16
) (
    input  logic                   csi_clk,
    input  logic                   rsi_reset_n,
    input  logic [WIDTH_BITS-1:0]  cfg_width_beats,
    input  logic [HEIGHT_BITS-1:0] cfg_height,
    output logic                   axs_tready,
    input  logic                   axs_tvalid,
    input  logic [BITS_AXI-1:0]    axs_tdata,
    input  logic                   axs_tlast,
    input  logic [TUSER_BITS-1:0]  axs_tuser,
    input  logic                   axm_tready,
    output logic                   axm_tvalid,
    output logic [BITS_AXI-1:0]    axm_tdata,
    output logic                   axm_tlast,
    output logic [TUSER_BITS-1:0]  axm_tuser,
    output logic                   stat_pad,
    output logic                   stat_trunc,
    output logic                   stat_drop
`ifdef ONEAPI_LINE_REGULATOR_STATS_EN
    ,
    input  logic                     stat_clear,
    output logic [STAT_CNT_BITS-1:0] stat_pad_count,
    output logic [STAT_CNT_BITS-1:0] stat_trunc_count,
    output logic [STAT_CNT_BITS-1:0] stat_drop_count
`endif
);

    localparam int PAYLOAD_BITS = TUSER_BITS + 1 + BITS_AXI;

    state_t                   state_q, state_d;
    logic                     pad_eof_q, pad_eof_d;
    logic [WIDTH_BITS-1:0]    col_q, width_q, w_eff;
    logic [HEIGHT_BITS-1:0]   row_q, height_q, h_eff;

    logic                     sof_in;
    logic                     cfg_zero;
    logic                     at_origin, at_eol, at_eof;
    logic                     buf_ready;
    logic                     tready_c;
    logic                     take_beat;
    logic                     latch_cfg;
    logic                     push;
    logic [BITS_AXI-1:0]      push_data;
    logic [TUSER_BITS-1:0]    push_tuser;
    logic [PAYLOAD_BITS-1:0]  out_payload;
    logic                     pad_pulse, trunc_pulse, drop_pulse;
    logic                     tuser_unused;

    assign sof_in       = axs_tuser[TUSER_SOF_BIT];
    assign tuser_unused = ^axs_tuser;
    assign cfg_zero     = (cfg_width_beats == '0) || (cfg_height == '0);

    // In IDLE the geometry being applied to the incoming SOF beat is the live
    // config, since it is latched on that same beat. col/row are always 0 in IDLE.
    assign w_eff     = (state_q == IDLE) ? cfg_width_beats : width_q;
    assign h_eff     = (state_q == IDLE) ? cfg_height : height_q;
    assign at_origin = (col_q == '0) && (row_q == '0);
    assign at_eol    = (col_q == w_eff - WIDTH_BITS'(1));
    assign at_eof    = at_eol && (row_q == h_eff - HEIGHT_BITS'(1));

    always_comb begin
        state_d     = state_q;
        pad_eof_d   = pad_eof_q;
        tready_c    = 1'b0;
        take_beat   = 1'b0;
        latch_cfg   = 1'b0;
        push        = 1'b0;
        push_data   = axs_tdata;
        pad_pulse   = 1'b0;
        trunc_pulse = 1'b0;
        drop_pulse  = 1'b0;

        case (state_q)
            IDLE: begin
                // A valid SOF is held off while the buffer is full rather than lost;
                // everything else is swallowed unconditionally.
                if (sof_in && !cfg_zero) begin
                    tready_c = buf_ready;
                    if (axs_tvalid && buf_ready) begin
                        latch_cfg = 1'b1;
                        take_beat = 1'b1;
                    end
                end else begin
                    tready_c = 1'b1;
                    drop_pulse = axs_tvalid;
                end
            end
            PASS: begin
                // An SOF away from (0,0) is left on the bus; the frame is closed
                // with padding and the SOF is picked up again from IDLE.
                tready_c = buf_ready && !(sof_in && !at_origin);
                if (axs_tvalid && sof_in && !at_origin) begin
                    state_d   = PAD;
                    pad_eof_d = 1'b1;
                end else if (axs_tvalid && buf_ready) begin
                    take_beat = 1'b1;
                end
            end
            PAD: begin
                push_data = '0;
                if (buf_ready) begin
                    push = 1'b1;
                    if (at_eof) begin
                        state_d = IDLE;
                    end else if (at_eol && !pad_eof_q) begin
                        state_d = PASS;
                    end
                end
            end
            default: begin
                // DROP: col/row sit at (0,0) here only once the frame is complete.
                tready_c = !sof_in;
                if (axs_tvalid && sof_in) begin
                    if (at_origin) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = PAD;
                        pad_eof_d = 1'b1;
                    end
                end else if (axs_tvalid) begin
                    drop_pulse = 1'b1;
                    if (axs_tlast) begin
                        state_d = at_origin ? IDLE : PASS;
                    end
                end
            end
        endcase

        if (take_beat) begin
            push = 1'b1;
            if (at_eol && axs_tlast) begin
                state_d = at_eof ? IDLE : PASS;
            end else if (at_eol) begin
                trunc_pulse = 1'b1;
                state_d     = DROP;
            end else if (axs_tlast) begin
                pad_pulse = 1'b1;
                state_d   = PAD;
                pad_eof_d = 1'b0;
            end else begin
                state_d = PASS;
            end
        end
    end

    assign axs_tready = rsi_reset_n && tready_c;
    assign push_tuser = TUSER_BITS'(at_origin) << TUSER_SOF_BIT;

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            state_q    <= IDLE;
            pad_eof_q  <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            width_q    <= '0;
            height_q   <= '0;
            stat_pad   <= 1'b0;
            stat_trunc <= 1'b0;
            stat_drop  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pad_eof_q  <= pad_eof_d;
            stat_pad   <= pad_pulse;
            stat_trunc <= trunc_pulse;
            stat_drop  <= drop_pulse;
            if (latch_cfg) begin
                width_q  <= cfg_width_beats;
                height_q <= cfg_height;
            end
            if (push) begin
                if (at_eol) begin
                    col_q <= '0;
                    row_q <= at_eof ? '0 : row_q + HEIGHT_BITS'(1);
                end else begin
                    col_q <= col_q + WIDTH_BITS'(1);
                end
            end
        end
    end

    oneapi_axis_skid_buffer #(
        .DATA_BITS (PAYLOAD_BITS)
    ) u_skid (
        .clk       (csi_clk),
        .rst_n     (rsi_reset_n),
        .in_valid  (push),
        .in_ready  (buf_ready),
        .in_data   ({push_tuser, at_eol, push_data}),
        .out_valid (axm_tvalid),
        .out_ready (axm_tready),
        .out_data  (out_payload)
    );

    assign {axm_tuser, axm_tlast, axm_tdata} = out_payload;

`ifdef ONEAPI_LINE_REGULATOR_STATS_EN
    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n || stat_clear) begin
            stat_pad_count   <= '0;
            stat_trunc_count <= '0;
            stat_drop_count  <= '0;
        end else begin
            if (pad_pulse)   stat_pad_count   <= sat_inc(stat_pad_count);
            if (trunc_pulse) stat_trunc_count <= sat_inc(stat_trunc_count);
            if (drop_pulse)  stat_drop_count  <= sat_inc(stat_drop_count);
        end
    end
`endif

endmodule

// File: tb/tb_oneapi_axi_video_line_regulator.sv
// Directed bench for oneapi_axi_video_line_regulator: expected beats are queued
// as stimulus is driven and compared against beats observed on the source port.
module tb_oneapi_axi_video_line_regulator;

    typedef struct packed {
        logic [23:0] d;
        logic        last;
        logic [2:0]  user;
    } beat_t;

    logic        csi_clk = 1'b0;
    logic        rsi_reset_n;
    logic [15:0] cfg_width_beats;
    logic [15:0] cfg_height;
    logic        axs_tready;
    logic        axs_tvalid;
    logic [23:0] axs_tdata;
    logic        axs_tlast;
    logic [2:0]  axs_tuser;
    logic        axm_tready;
    logic        axm_tvalid;
    logic [23:0] axm_tdata;
    logic        axm_tlast;
    logic [2:0]  axm_tuser;
    logic        stat_pad;
    logic        stat_trunc;
    logic        stat_drop;
`ifdef ONEAPI_LINE_REGULATOR_STATS_EN
    logic        stat_clear = 1'b0;
    logic [15:0] stat_pad_count;
    logic [15:0] stat_trunc_count;
    logic [15:0] stat_drop_count;
`endif

    logic rdy_lvl;
    logic toggle_en;
    logic phase = 1'b0;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    n_pad = 0;
    int    n_trunc = 0;
    int    n_drop = 0;
    int    total = 0;
    int    passed = 0;
    int    p0, t0, d0;

    always #5 csi_clk = ~csi_clk;

    always @(posedge csi_clk) begin
        #1;
        phase = ~phase;
    end

    assign axm_tready = toggle_en ? phase : rdy_lvl;

    oneapi_axi_video_line_regulator dut (
        .csi_clk         (csi_clk),
        .rsi_reset_n     (rsi_reset_n),
        .cfg_width_beats (cfg_width_beats),
        .cfg_height      (cfg_height),
        .axs_tready      (axs_tready),
        .axs_tvalid      (axs_tvalid),
        .axs_tdata       (axs_tdata),
        .axs_tlast       (axs_tlast),
        .axs_tuser       (axs_tuser),
        .axm_tready      (axm_tready),
        .axm_tvalid      (axm_tvalid),
        .axm_tdata       (axm_tdata),
        .axm_tlast       (axm_tlast),
        .axm_tuser       (axm_tuser),
        .stat_pad        (stat_pad),
        .stat_trunc      (stat_trunc),
        .stat_drop       (stat_drop)
`ifdef ONEAPI_LINE_REGULATOR_STATS_EN
        ,
        .stat_clear      (stat_clear),
        .stat_pad_count  (stat_pad_count),
        .stat_trunc_count(stat_trunc_count),
        .stat_drop_count (stat_drop_count)
`endif
    );

    // Monitor: output transfers and stat pulses, sampled mid-cycle.
    always @(negedge csi_clk) begin
        if (rsi_reset_n) begin
            if (axm_tvalid && axm_tready) obs_q.push_back('{axm_tdata, axm_tlast, axm_tuser});
            if (stat_pad)   n_pad++;
            if (stat_trunc) n_trunc++;
            if (stat_drop)  n_drop++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed = passed + 1;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic expect_beat(input logic [23:0] d, input logic last, input logic sof);
        exp_q.push_back('{d, last, {2'b00, sof}});
    endtask

    task automatic send(input logic [23:0] d, input logic last, input logic sof);
        int   n = 0;
        logic acc = 1'b0;
        axs_tvalid = 1'b1;
        axs_tdata  = d;
        axs_tlast  = last;
        axs_tuser  = {2'b00, sof};
        while (!acc && n < 300) begin
            @(negedge csi_clk);
            acc = axs_tready;
            @(posedge csi_clk);
            #1;
            n++;
        end
        axs_tvalid = 1'b0;
        axs_tlast  = 1'b0;
        axs_tuser  = 3'b000;
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic send_frame(input int w, input int h, input logic [23:0] base);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                expect_beat(base + 24'(r * w + c), c == w - 1, (r == 0) && (c == 0));
                send(base + 24'(r * w + c), c == w - 1, (r == 0) && (c == 0));
            end
        end
    endtask

    task automatic snap();
        p0 = n_pad;
        t0 = n_trunc;
        d0 = n_drop;
    endtask

    task automatic drain(input string tag);
        int    n = 0;
        beat_t e, o;
        while (obs_q.size() < exp_q.size() && n < 500) begin
            @(posedge csi_clk);
            n++;
        end
        repeat (6) @(posedge csi_clk);
        #1;
        chk({tag, "_beat_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_tdata"}, 32'(o.d), 32'(e.d));
            chk({tag, "_tlast"}, 32'(o.last), 32'(e.last));
            chk({tag, "_tuser"}, 32'(o.user), 32'(e.user));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic chk_stats(input string tag, input int pad, input int trunc, input int drop);
        chk({tag, "_pad_pulses"},   32'(n_pad - p0),   32'(pad));
        chk({tag, "_trunc_pulses"}, 32'(n_trunc - t0), 32'(trunc));
        chk({tag, "_drop_pulses"},  32'(n_drop - d0),  32'(drop));
    endtask

    initial begin
        rsi_reset_n     = 1'b0;
        rdy_lvl         = 1'b1;
        toggle_en       = 1'b0;
        cfg_width_beats = 16'd4;
        cfg_height      = 16'd2;
        axs_tvalid      = 1'b1;
        axs_tdata       = 24'h00ABCD;
        axs_tlast       = 1'b0;
        axs_tuser       = 3'b001;
        repeat (3) @(posedge csi_clk);
        @(negedge csi_clk);
        chk("rst_axs_tready", 32'(axs_tready), 32'd0);
        chk("rst_axm_tvalid", 32'(axm_tvalid), 32'd0);
        chk("rst_axm_tdata",  32'(axm_tdata),  32'd0);
        chk("rst_stats", 32'({stat_pad, stat_trunc, stat_drop}), 32'd0);
        @(posedge csi_clk);
        #1;
        axs_tvalid  = 1'b0;
        axs_tuser   = 3'b000;
        rsi_reset_n = 1'b1;
        repeat (2) @(posedge csi_clk);
        #1;

        // Two clean W=4 H=2 frames
        snap();
        send_frame(4, 2, 24'h000100);
        send_frame(4, 2, 24'h000200);
        drain("clean");
        chk_stats("clean", 0, 0, 0);

        // Short line: 2 beats, W=4 H=1; also first-beat latency
        cfg_width_beats = 16'd4;
        cfg_height      = 16'd1;
        snap();
        expect_beat(24'h0A0000, 1'b0, 1'b1);
        expect_beat(24'h0A0001, 1'b0, 1'b0);
        expect_beat(24'h000000, 1'b0, 1'b0);
        expect_beat(24'h000000, 1'b1, 1'b0);
        send(24'h0A0000, 1'b0, 1'b1);
        chk("latency_tvalid", 32'(axm_tvalid), 32'd1);
        chk("latency_tdata",  32'(axm_tdata),  32'h0A0000);
        send(24'h0A0001, 1'b1, 1'b0);
        drain("pad");
        chk_stats("pad", 1, 0, 0);

        // Long line: 6 beats, W=4 H=1
        snap();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expect_beat(24'h0B0000 + 24'(i), i == 3, i == 0);
            send(24'h0B0000 + 24'(i), i == 5, i == 0);
        end
        drain("trunc");
        chk_stats("trunc", 0, 1, 2);

        // Early SOF at row0 col2, W=4 H=2
        cfg_width_beats = 16'd4;
        cfg_height      = 16'd2;
        snap();
        expect_beat(24'h0C0000, 1'b0, 1'b1);
        expect_beat(24'h0C0001, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) expect_beat(24'h000000, (i == 1) || (i == 5), 1'b0);
        send(24'h0C0000, 1'b0, 1'b1);
        send(24'h0C0001, 1'b0, 1'b0);
        send_frame(4, 2, 24'h000400);
        drain("early_sof");
        chk("early_sof_drop_pulses",  32'(n_drop - d0),  32'd0);
        chk("early_sof_trunc_pulses", 32'(n_trunc - t0), 32'd0);

        // Backpressure 1010... during W=8 frames
        cfg_width_beats = 16'd8;
        cfg_height      = 16'd2;
        toggle_en       = 1'b1;
        snap();
        send_frame(8, 2, 24'h000500);
        drain("toggle");
        chk_stats("toggle", 0, 0, 0);
        toggle_en = 1'b0;

        // Boundaries: non-SOF in IDLE, zero width, zero height, W=1 H=1 and W=1 H=2
        snap();
        send(24'h0E0000, 1'b0, 1'b0);
        cfg_width_beats = 16'd0;
        cfg_height      = 16'd1;
        send(24'h0E0001, 1'b1, 1'b1);
        cfg_width_beats = 16'd4;
        cfg_height      = 16'd0;
        send(24'h0E0002, 1'b1, 1'b1);
        cfg_width_beats = 16'd1;
        cfg_height      = 16'd1;
        expect_beat(24'h0E0003, 1'b1, 1'b1);
        send(24'h0E0003, 1'b1, 1'b1);
        cfg_height = 16'd2;
        send_frame(1, 2, 24'h0E0010);
        drain("bounds");
        chk_stats("bounds", 0, 0, 3);

        // Reset mid-line with a stalled source
        cfg_width_beats = 16'd8;
        cfg_height      = 16'd1;
        rdy_lvl         = 1'b0;
        send(24'h0F0000, 1'b0, 1'b1);
        send(24'h0F0001, 1'b0, 1'b0);
        @(negedge csi_clk);
        chk("stall_tvalid", 32'(axm_tvalid), 32'd1);
        chk("stall_tdata",  32'(axm_tdata),  32'h0F0000);
        @(posedge csi_clk);
        #1;
        chk("stall_stable_tdata", 32'(axm_tdata), 32'h0F0000);
        rsi_reset_n = 1'b0;
        @(posedge csi_clk);
        @(negedge csi_clk);
        chk("midrst_axm_tvalid", 32'(axm_tvalid), 32'd0);
        chk("midrst_axs_tready", 32'(axs_tready), 32'd0);
        @(posedge csi_clk);
        #1;
        rsi_reset_n = 1'b1;
        rdy_lvl     = 1'b1;
        repeat (5) @(posedge csi_clk);
        #1;
        chk("midrst_no_partial", 32'(obs_q.size()), 32'd0);
        snap();
        send_frame(8, 1, 24'h000700);
        drain("post_rst");
        chk_stats("post_rst", 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
